// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one single-port unified memory between instruction fetch (read-only)
// and the memory-access stage (loads/stores). Data accesses win by default; a fetch that
// has lost STARVE_LIMIT consecutive cycles is given priority until it is served. Read
// responses come back in order and are steered to their requester by an owner-tag FIFO.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr/if_gnt          fetch request channel
//   if_rsp_valid/if_rsp_data       fetch read response
//   ma_req/ma_wr_en/ma_addr/
//   ma_wr_data/ma_byte_en/ma_gnt   data request channel
//   ma_rsp_valid/ma_rsp_data       load response
//   mem_req..mem_byte_en           request to memory, mem_ready accepts it
//   mem_rsp_valid/mem_rsp_data     in-order read data from memory
//   err_orphan                     sticky: response arrived with no read outstanding
module rv_mem_arb #(
    parameter int unsigned MAX_OUTST    = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        ma_req,
    input  logic        ma_wr_en,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wr_data,
    input  logic [3:0]  ma_byte_en,
    output logic        ma_gnt,
    output logic        ma_rsp_valid,
    output logic [31:0] ma_rsp_data,
    output logic        mem_req,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        err_orphan
);

    localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] MaxCnt   = CntW'(MAX_OUTST);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(MAX_OUTST - 1);
    localparam logic [StW-1:0]  LimitCnt = StW'(STARVE_LIMIT);

    typedef enum logic [0:0] {DataPri, FetchPri} pri_e;

    pri_e            state;
    logic [StW-1:0]  starve_cnt;
    logic [StW-1:0]  starve_inc;
    logic            tags [MAX_OUTST];  // 0 = fetch, 1 = data
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] cnt;
    logic            err_q;

    logic active;
    logic sel_ma;
    logic win_req;
    logic is_store;
    logic can_issue;
    logic grant;
    logic push;
    logic pop;
    logic head;

    assign active  = ~rst;
    // Winner is chosen even when only one side requests, so the FSM only breaks ties.
    assign sel_ma  = (state == DataPri) ? ma_req : ~if_req;
    assign win_req = sel_ma ? ma_req : if_req;

    assign mem_req     = active & win_req;
    assign mem_wr_en   = mem_req & sel_ma & ma_wr_en;
    assign mem_addr    = !mem_req ? 32'h0 : (sel_ma ? ma_addr : if_addr);
    assign mem_wr_data = (mem_req & sel_ma & ma_wr_en) ? ma_wr_data : 32'h0;
    assign mem_byte_en = !mem_req ? 4'h0 : (sel_ma ? ma_byte_en : 4'hf);

    // A response popping this cycle frees a slot, so a full FIFO can still accept a read.
    assign is_store  = sel_ma & ma_wr_en;
    assign can_issue = mem_ready & (is_store | (cnt != MaxCnt) | mem_rsp_valid);
    assign grant     = mem_req & can_issue;
    assign if_gnt    = grant & ~sel_ma;
    assign ma_gnt    = grant & sel_ma;
    assign push      = grant & ~is_store;

    assign pop          = active & mem_rsp_valid & (cnt != '0);
    assign head         = tags[rd_ptr];
    assign if_rsp_valid = pop & ~head;
    assign ma_rsp_valid = pop & head;
    assign if_rsp_data  = active ? mem_rsp_data : 32'h0;
    assign ma_rsp_data  = active ? mem_rsp_data : 32'h0;
    assign err_orphan   = active & err_q;

    assign starve_inc = starve_cnt + StW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DataPri;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                DataPri: begin
                    if (if_req && !if_gnt) begin
                        starve_cnt <= starve_inc;
                        if (starve_inc == LimitCnt) state <= FetchPri;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                FetchPri: begin
                    if (if_gnt || !if_req) begin
                        state      <= DataPri;
                        starve_cnt <= '0;
                    end
                end
                default: state <= DataPri;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= sel_ma;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
            if (push && !pop)      cnt <= cnt + CntW'(1);
            else if (pop && !push) cnt <= cnt - CntW'(1);
            if (mem_rsp_valid && cnt == '0) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed self-checking bench for rv_mem_arb (MAX_OUTST=4, STARVE_LIMIT=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_rv_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ma_req;
    logic        ma_wr_en;
    logic [31:0] ma_addr;
    logic [31:0] ma_wr_data;
    logic [3:0]  ma_byte_en;
    logic        ma_gnt;
    logic        ma_rsp_valid;
    logic [31:0] ma_rsp_data;
    logic        mem_req;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_en;
    logic        mem_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        err_orphan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv_mem_arb #(
        .MAX_OUTST   (4),
        .STARVE_LIMIT(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .ma_req       (ma_req),
        .ma_wr_en     (ma_wr_en),
        .ma_addr      (ma_addr),
        .ma_wr_data   (ma_wr_data),
        .ma_byte_en   (ma_byte_en),
        .ma_gnt       (ma_gnt),
        .ma_rsp_valid (ma_rsp_valid),
        .ma_rsp_data  (ma_rsp_data),
        .mem_req      (mem_req),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_byte_en  (mem_byte_en),
        .mem_ready    (mem_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .err_orphan   (err_orphan)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req        = 1'b0;
        if_addr       = 32'h0;
        ma_req        = 1'b0;
        ma_wr_en      = 1'b0;
        ma_addr       = 32'h0;
        ma_wr_data    = 32'h0;
        ma_byte_en    = 4'h0;
        mem_ready     = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst           = 1'b1;
        if_req        = 1'b1;
        if_addr       = 32'h0000_1000;
        ma_req        = 1'b1;
        ma_addr       = 32'h0000_2000;
        mem_ready     = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hdead_beef;
        tick();
        tick();
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
        total++; if ({if_gnt, ma_gnt} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {if_gnt, ma_gnt}); end
        total++; if ({if_rsp_valid, ma_rsp_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {if_rsp_valid, ma_rsp_valid}); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        total++; if (if_rsp_data !== 32'h0 || ma_rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h/%h exp=0", if_rsp_data, ma_rsp_data); end
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_orphan); end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0100;
        mem_ready = 1'b1;
        #1;
        total++; if (if_gnt !== 1'b1 || ma_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt got=%b%b exp=10", if_gnt, ma_gnt); end
        total++; if (mem_req !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 32'h0000_0100) begin bad++; $display("FAIL fetch_mem got req=%b we=%b addr=%h exp 1 0 00000100", mem_req, mem_wr_en, mem_addr); end
        total++; if (mem_byte_en !== 4'hf) begin bad++; $display("FAIL fetch_be got=%h exp=f", mem_byte_en); end
        tick();
        if_req        = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'haaaa_5555;
        #1;
        total++; if (if_rsp_valid !== 1'b1 || ma_rsp_valid !== 1'b0) begin bad++; $display("FAIL fetch_rsp_valid got=%b%b exp=10", if_rsp_valid, ma_rsp_valid); end
        total++; if (if_rsp_data !== 32'haaaa_5555) begin bad++; $display("FAIL fetch_rsp_data got=%h exp=aaaa5555", if_rsp_data); end
        tick();
        idle_inputs();
    endtask

    task automatic test_contention();
        mem_ready  = 1'b1;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0104;
        ma_req     = 1'b1;
        ma_wr_en   = 1'b0;
        ma_addr    = 32'h0000_0200;
        ma_byte_en = 4'b0011;
        #1;
        total++; if (ma_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL cont_first_gnt got ma=%b if=%b exp 1 0", ma_gnt, if_gnt); end
        total++; if (mem_addr !== 32'h0000_0200 || mem_byte_en !== 4'b0011) begin bad++; $display("FAIL cont_mux got addr=%h be=%h exp 00000200 3", mem_addr, mem_byte_en); end
        tick();
        ma_req        = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_2222;
        #1;
        total++; if (if_gnt !== 1'b1 || ma_gnt !== 1'b0) begin bad++; $display("FAIL cont_second_gnt got if=%b ma=%b exp 1 0", if_gnt, ma_gnt); end
        total++; if (ma_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0 || ma_rsp_data !== 32'h1111_2222) begin bad++; $display("FAIL cont_rsp_ma got ma=%b if=%b d=%h exp 1 0 11112222", ma_rsp_valid, if_rsp_valid, ma_rsp_data); end
        tick();
        if_req       = 1'b0;
        mem_rsp_data = 32'h3333_4444;
        #1;
        total++; if (if_rsp_valid !== 1'b1 || ma_rsp_valid !== 1'b0 || if_rsp_data !== 32'h3333_4444) begin bad++; $display("FAIL cont_rsp_if got if=%b ma=%b d=%h exp 1 0 33334444", if_rsp_valid, ma_rsp_valid, if_rsp_data); end
        tick();
        idle_inputs();
    endtask

    // Stores hold the memory; fetch is forced through after 3 lost cycles, twice.
    task automatic test_starvation();
        logic exp_if;
        mem_ready  = 1'b1;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0400;
        ma_req     = 1'b1;
        ma_wr_en   = 1'b1;
        ma_addr    = 32'h0000_0300;
        ma_wr_data = 32'hcafe_f00d;
        ma_byte_en = 4'hf;
        for (int k = 1; k <= 10; k++) begin
            exp_if = (k == 4) || (k == 8);
            #1;
            total++; if (if_gnt !== exp_if || ma_gnt !== !exp_if) begin bad++; $display("FAIL starve_cycle%0d got if=%b ma=%b exp if=%b", k, if_gnt, ma_gnt, exp_if); end
            if (k == 1) begin
                total++; if (mem_wr_en !== 1'b1 || mem_wr_data !== 32'hcafe_f00d) begin bad++; $display("FAIL starve_store got we=%b d=%h exp 1 cafef00d", mem_wr_en, mem_wr_data); end
            end
            tick();
        end
        idle_inputs();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0bad_0400;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (if_rsp_valid !== 1'b1 || ma_rsp_valid !== 1'b0) begin bad++; $display("FAIL starve_drain%0d got if=%b ma=%b exp 1 0", k, if_rsp_valid, ma_rsp_valid); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_outstanding_limit();
        mem_ready  = 1'b1;
        ma_req     = 1'b1;
        ma_wr_en   = 1'b0;
        ma_addr    = 32'h0000_0500;
        ma_byte_en = 4'hf;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (ma_gnt !== 1'b1) begin bad++; $display("FAIL limit_fill%0d got=%b exp=1", k, ma_gnt); end
            tick();
        end
        #1;
        total++; if (ma_gnt !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL limit_full_read got gnt=%b req=%b exp 0 1", ma_gnt, mem_req); end
        ma_wr_en = 1'b1;
        #1;
        total++; if (ma_gnt !== 1'b1 || mem_wr_en !== 1'b1) begin bad++; $display("FAIL limit_store got gnt=%b we=%b exp 1 1", ma_gnt, mem_wr_en); end
        tick();
        ma_wr_en  = 1'b0;
        mem_ready = 1'b0;
        #1;
        total++; if (ma_gnt !== 1'b0) begin bad++; $display("FAIL limit_not_ready got=%b exp=0", ma_gnt); end
        mem_ready     = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_0000;
        #1;
        total++; if (ma_gnt !== 1'b1 || ma_rsp_valid !== 1'b1) begin bad++; $display("FAIL limit_push_pop got gnt=%b rsp=%b exp 1 1", ma_gnt, ma_rsp_valid); end
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        total++; if (ma_gnt !== 1'b0) begin bad++; $display("FAIL limit_still_full got=%b exp=0", ma_gnt); end
        ma_req        = 1'b0;
        mem_rsp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (ma_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0) begin bad++; $display("FAIL limit_drain%0d got ma=%b if=%b exp 1 0", k, ma_rsp_valid, if_rsp_valid); end
            tick();
        end
        idle_inputs();
        #1;
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL limit_no_orphan got=%b exp=0", err_orphan); end
    endtask

    task automatic test_orphan();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_7777;
        #1;
        total++; if (if_rsp_valid !== 1'b0 || ma_rsp_valid !== 1'b0) begin bad++; $display("FAIL orphan_rsp got if=%b ma=%b exp 0 0", if_rsp_valid, ma_rsp_valid); end
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
        tick();
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_cleared got=%b exp=0", err_orphan); end
    endtask

    task automatic test_mid_reset();
        mem_ready = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0600;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL midrst_issue%0d got=%b exp=1", k, if_gnt); end
            tick();
        end
        // Memory stalls while a load competes: fetch loses 3 cycles and gains priority.
        mem_ready  = 1'b0;
        ma_req     = 1'b1;
        ma_wr_en   = 1'b0;
        ma_addr    = 32'h0000_0700;
        ma_byte_en = 4'hf;
        tick();
        tick();
        tick();
        #1;
        total++; if (mem_addr !== 32'h0000_0600) begin bad++; $display("FAIL midrst_fetch_pri got=%h exp=00000600", mem_addr); end
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || if_gnt !== 1'b0 || ma_gnt !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL midrst_outputs got req=%b if=%b ma=%b addr=%h exp all 0", mem_req, if_gnt, ma_gnt, mem_addr); end
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        total++; if (mem_addr !== 32'h0000_0700 || if_gnt !== 1'b0) begin bad++; $display("FAIL midrst_data_pri got addr=%h if=%b exp 00000700 0", mem_addr, if_gnt); end
        if_req        = 1'b0;
        ma_req        = 1'b0;
        mem_rsp_valid = 1'b1;
        #1;
        total++; if (if_rsp_valid !== 1'b0 || ma_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_fifo_empty got if=%b ma=%b exp 0 0", if_rsp_valid, ma_rsp_valid); end
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL midrst_orphan got=%b exp=1", err_orphan); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_contention();
        test_starvation();
        test_outstanding_limit();
        test_orphan();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
